// File: rtl/fp_input_wrapper.sv
// fp_input_wrapper: collects operands A and B from a byte-wide producer bus,
// pulses startFP to the FP core, and holds the operands until doneFP.
// Optional feature macro: INWRAP_PARITY_EN (odd parity check per beat,
// adds the dataParity input and drives parityErr).
module fp_input_wrapper #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OPERAND_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    dataIn,
  input  logic                 dataReady,
  output logic                 dataAccept,
`ifdef INWRAP_PARITY_EN
  input  logic                 dataParity,
`endif
  output logic [OPERAND_W-1:0] opA,
  output logic [OPERAND_W-1:0] opB,
  output logic                 startFP,
  input  logic                 doneFP,
  output logic                 busy,
  output logic                 parityErr
);

  localparam int unsigned BEATS = OPERAND_W / DATA_W;
  localparam int unsigned CNT_W = (2 * BEATS > 1) ? $clog2(2 * BEATS) : 1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [OPERAND_W-1:0] r_opA;
  logic [OPERAND_W-1:0] r_opB;
  logic                 r_parity_err;
  logic                 w_par_err_nxt;
  logic                 w_wr_en;
  logic                 w_par_ok;
  logic                 w_cnt_last;

  // Beat integrity: odd parity over data plus parity bit when enabled
`ifdef INWRAP_PARITY_EN
  assign w_par_ok = ^{dataIn, dataParity};
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_cnt_last = (r_cnt == CNT_W'(2 * BEATS - 1));

  // Next-state, counter and write-enable decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wr_en       = 1'b0;
    w_par_err_nxt = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (dataReady) begin
          if (!w_par_ok) begin
            // Bad beat is consumed but restarts the whole A/B set
            w_cnt_nxt     = '0;
            w_par_err_nxt = 1'b1;
          end else begin
            w_wr_en = 1'b1;
            if (w_cnt_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_START;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (doneFP) w_state_nxt = ST_COLLECT;
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  // State, counter and parity-error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_COLLECT;
      r_cnt        <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_parity_err <= w_par_err_nxt;
    end
  end

  // Operand assembly: beat k lands in slice k, LS beat first, A then B
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA <= '0;
      r_opB <= '0;
    end else if (w_wr_en) begin
      for (int k = 0; k < int'(BEATS); k++) begin
        if (r_cnt == CNT_W'(k))
          r_opA[k*DATA_W +: DATA_W] <= dataIn;
        if (r_cnt == CNT_W'(k + int'(BEATS)))
          r_opB[k*DATA_W +: DATA_W] <= dataIn;
      end
    end
  end

  assign dataAccept = (r_state == ST_COLLECT);
  assign startFP    = (r_state == ST_START);
  assign busy       = (r_state == ST_START) || (r_state == ST_WAIT);
  assign opA        = r_opA;
  assign opB        = r_opB;
  assign parityErr  = r_parity_err;

endmodule

// File: tb/tb_fp_input_wrapper.sv
// Scoreboard bench for fp_input_wrapper: stimulus pushes expected {opA,opB}
// per operation; a monitor pops and compares on every startFP pulse.
module tb_fp_input_wrapper;

  logic        clk;
  logic        rst;
  logic [7:0]  dataIn;
  logic        dataReady;
  logic        dataAccept;
`ifdef INWRAP_PARITY_EN
  logic        dataParity;
`endif
  logic [31:0] opA;
  logic [31:0] opB;
  logic        startFP;
  logic        doneFP;
  logic        busy;
  logic        parityErr;

  int          n_tests;
  int          n_fail;
  logic [63:0] exp_q[$];

  fp_input_wrapper #(.DATA_W(8), .OPERAND_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .dataIn     (dataIn),
    .dataReady  (dataReady),
    .dataAccept (dataAccept),
`ifdef INWRAP_PARITY_EN
    .dataParity (dataParity),
`endif
    .opA        (opA),
    .opB        (opB),
    .startFP    (startFP),
    .doneFP     (doneFP),
    .busy       (busy),
    .parityErr  (parityErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic good);
    dataIn = d;
`ifdef INWRAP_PARITY_EN
    dataParity = good ? ~(^d) : (^d);
`else
    if (!good) dataIn = d;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Stream all 8 beats with dataReady held high; leaves the DUT in Start
  task automatic load_op(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] w;
    w = {b, a};
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      drive_beat(w[i*8 +: 8], 1'b1);
      dataReady = 1'b1;
      tick();
    end
    dataReady = 1'b0;
  endtask

  task automatic finish_op();
    doneFP = 1'b1;
    tick();
    doneFP = 1'b0;
  endtask

  // Monitor: compare assembled operands whenever the core is started
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (startFP === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_startFP actual=%h_%h expected=none", opA, opB);
        end else begin
          e = exp_q.pop_front();
          if ({opB, opA} !== e) begin
            n_fail++;
            $display("FAIL operands actual=%h_%h expected=%h_%h", opB, opA, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] w;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    dataIn    = '0;
    dataReady = 1'b0;
    doneFP    = 1'b0;
`ifdef INWRAP_PARITY_EN
    dataParity = 1'b0;
`endif

    // Reset values
    do_reset();
    chk("rst_dataAccept", 64'(dataAccept), 64'd1);
    chk("rst_startFP",    64'(startFP),    64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_parityErr",  64'(parityErr),  64'd0);
    chk("rst_ops",        {opB, opA},      64'd0);

    // Streamed beats; doneFP during Start is ignored, Wait lasts 3 cycles
    load_op(32'h44332211, 32'h88776655);
    chk("start_startFP",    64'(startFP),    64'd1);
    chk("start_busy",       64'(busy),       64'd1);
    chk("start_dataAccept", 64'(dataAccept), 64'd0);
    doneFP = 1'b1;
    tick();
    doneFP = 1'b0;
    chk("wait_startFP",    64'(startFP),    64'd0);
    chk("wait_busy",       64'(busy),       64'd1);
    chk("wait_dataAccept", 64'(dataAccept), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_hold_busy", 64'(busy),  64'd1);
      chk("wait_hold_ops",  {opB, opA}, 64'h88776655_44332211);
    end
    finish_op();
    chk("done_dataAccept", 64'(dataAccept), 64'd1);
    chk("done_busy",       64'(busy),       64'd0);
    chk("done_ops",        {opB, opA},      64'h88776655_44332211);

    // Gaps in dataReady: junk on idle cycles must not be captured
    do_reset();
    w = 64'h88776655_44332211;
    exp_q.push_back(w);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        drive_beat(w[(i/2)*8 +: 8], 1'b1);
        dataReady = 1'b1;
      end else begin
        drive_beat(8'hFF, 1'b1);
        dataReady = 1'b0;
      end
      tick();
      if (i == 13) chk("gap_not_started", 64'(busy), 64'd0);
    end
    chk("gap_busy_after16", 64'(busy), 64'd1);
    chk("gap_ops", {opB, opA}, w);
    finish_op();

    // Reset mid-collection discards partial operands
    for (int i = 0; i < 5; i++) begin
      drive_beat(8'(8'hA0 + i), 1'b1);
      dataReady = 1'b1;
      tick();
    end
    dataReady = 1'b0;
    chk("partial_not_busy", 64'(busy), 64'd0);
    do_reset();
    chk("midrst_ops",        {opB, opA},      64'd0);
    chk("midrst_dataAccept", 64'(dataAccept), 64'd1);
    load_op(32'hDEADBEEF, 32'h01234567);
    chk("midrst_reload_start", 64'(startFP), 64'd1);
    tick();
    finish_op();

    // Back-to-back with doneFP held high: 10-cycle period, one-cycle pulses
    w = 64'h08070605_04030201;
    exp_q.push_back(w);
    exp_q.push_back(64'hB4B3B2B1_A4A3A2A1);
    doneFP    = 1'b1;
    dataReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) w = 64'hB4B3B2B1_A4A3A2A1;
      if (c % 10 < 8) drive_beat(w[(c%10)*8 +: 8], 1'b1);
      else            drive_beat(8'h5A, 1'b1);
      tick();
      chk("b2b_startFP", 64'(startFP), ((c + 1) % 10 == 8) ? 64'd1 : 64'd0);
    end
    doneFP    = 1'b0;
    dataReady = 1'b0;
    chk("b2b_back_in_collect", 64'(dataAccept), 64'd1);
    chk("parityErr_quiet", 64'(parityErr), 64'd0);

`ifdef INWRAP_PARITY_EN
    // Bad parity on 3rd beat restarts collection, no start
    do_reset();
    dataReady = 1'b1;
    drive_beat(8'h01, 1'b1); tick();
    drive_beat(8'h02, 1'b1); tick();
    drive_beat(8'h03, 1'b0); tick();
    dataReady = 1'b0;
    chk("par_err_pulse",  64'(parityErr),  64'd1);
    chk("par_err_accept", 64'(dataAccept), 64'd1);
    chk("par_err_busy",   64'(busy),       64'd0);
    tick();
    chk("par_err_oneshot", 64'(parityErr), 64'd0);
    load_op(32'h40302010, 32'h80706050);
    chk("par_reload_start", 64'(startFP), 64'd1);
    tick();
    finish_op();
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
